// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: lane-aligned RAM req/gnt/rvalid handshake, load extension, MMIO LED register.
// Latency: store 2 stall cycles, load 3 stall cycles minimum; MMIO store 0, MMIO load 1.
// Backpressure: lsu_stall_o holds the pipeline while a RAM op waits on gnt/rvalid; released in DONE.
module mem_stage_lsu #(
    parameter int                XLEN          = 32,
    parameter int                ALEN          = 32,
    parameter int                LED_WIDTH     = 4,
    parameter logic [ALEN-1:0]   MMIO_LED_ADDR = 32'hFFFF_FFF0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ex_valid_i,
    input  logic                 ex_mem_read_i,
    input  logic                 ex_mem_write_i,
    input  logic [2:0]           ex_funct3_i,
    input  logic [ALEN-1:0]      ex_addr_i,
    input  logic [XLEN-1:0]      ex_wdata_i,
    output logic                 lsu_stall_o,
    output logic                 load_valid_o,
    output logic [XLEN-1:0]      load_data_o,
    output logic                 misaligned_o,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [ALEN-1:0]      mem_addr_o,
    output logic [3:0]           mem_be_o,
    output logic [XLEN-1:0]      mem_wdata_o,
    input  logic                 mem_gnt_i,
    input  logic                 mem_rvalid_i,
    input  logic [XLEN-1:0]      mem_rdata_i,
    output logic [LED_WIDTH-1:0] led_o
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_R, S_DONE} state_t;

    state_t                state_q;
    logic [ALEN-1:0]       addr_q;
    logic [2:0]            funct3_q;
    logic                  we_q;
    logic [XLEN-1:0]       wdata_q;
    logic [XLEN-1:0]       load_data_q;
    logic                  misaligned_q;
    logic [LED_WIDTH-1:0]  led_q;

    logic                  accept;
    logic                  is_mmio;
    logic                  is_misaligned;
    logic [3:0]            be_d;
    logic [XLEN-1:0]       wdata_d;
    logic [XLEN-1:0]       load_ext_d;
    logic [7:0]            rbyte;
    logic [15:0]           rhalf;

    assign accept  = (state_q == S_IDLE) && ex_valid_i && (ex_mem_read_i || ex_mem_write_i);
    assign is_mmio = (ex_addr_i == MMIO_LED_ADDR);
    assign is_misaligned = ((ex_funct3_i[1:0] == 2'b01) && ex_addr_i[0])
                        || ((ex_funct3_i == 3'b010) && (ex_addr_i[1:0] != 2'b00));

    always_comb begin
        be_d       = 4'b1111;
        wdata_d    = wdata_q;
        rbyte      = mem_rdata_i[{addr_q[1:0], 3'b000} +: 8];
        rhalf      = addr_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        load_ext_d = mem_rdata_i;
        case (funct3_q[1:0])
            2'b00: begin
                be_d    = 4'b0001 << addr_q[1:0];
                wdata_d = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be_d    = addr_q[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{wdata_q[15:0]}};
            end
            default: ;
        endcase
        case (funct3_q)
            3'b000:  load_ext_d = {{(XLEN-8){rbyte[7]}}, rbyte};
            3'b001:  load_ext_d = {{(XLEN-16){rhalf[15]}}, rhalf};
            3'b100:  load_ext_d = {{(XLEN-8){1'b0}}, rbyte};
            3'b101:  load_ext_d = {{(XLEN-16){1'b0}}, rhalf};
            default: load_ext_d = mem_rdata_i;
        endcase
    end

    // Stall is gated by rst_n so every output reads 0 while reset is held.
    assign lsu_stall_o  = rst_n && ((accept && !is_misaligned && !(is_mmio && ex_mem_write_i))
                        || (state_q == S_REQ) || (state_q == S_WAIT_R));
    assign mem_req_o    = (state_q == S_REQ);
    assign mem_we_o     = (state_q == S_REQ) && we_q;
    assign mem_addr_o   = (state_q == S_REQ) ? {addr_q[ALEN-1:2], 2'b00} : '0;
    assign mem_be_o     = (state_q == S_REQ) ? be_d : 4'b0000;
    assign mem_wdata_o  = (state_q == S_REQ) ? wdata_d : '0;
    assign load_valid_o = (state_q == S_DONE) && !we_q;
    assign load_data_o  = load_data_q;
    assign misaligned_o = misaligned_q;
    assign led_o        = led_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            funct3_q     <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            load_data_q  <= '0;
            misaligned_q <= 1'b0;
            led_q        <= '0;
        end else begin
            misaligned_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        if (is_misaligned) begin
                            misaligned_q <= 1'b1;
                        end else if (is_mmio) begin
                            if (ex_mem_write_i) begin
                                led_q <= ex_wdata_i[LED_WIDTH-1:0];
                            end else begin
                                load_data_q <= XLEN'(led_q);
                                we_q        <= 1'b0;
                                state_q     <= S_DONE;
                            end
                        end else begin
                            addr_q   <= ex_addr_i;
                            funct3_q <= ex_funct3_i;
                            we_q     <= ex_mem_write_i;
                            wdata_q  <= ex_wdata_i;
                            state_q  <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_gnt_i) state_q <= we_q ? S_DONE : S_WAIT_R;
                end
                S_WAIT_R: begin
                    if (mem_rvalid_i) begin
                        load_data_q <= load_ext_d;
                        state_q     <= S_DONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid_i = 1'b0, ex_mem_read_i = 1'b0, ex_mem_write_i = 1'b0;
    logic [2:0]  ex_funct3_i = 3'b0;
    logic [31:0] ex_addr_i = '0, ex_wdata_i = '0;
    logic        lsu_stall_o, load_valid_o, misaligned_o;
    logic [31:0] load_data_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic [3:0]  led_o;

    int          n_assert = 0;
    int          n_fail = 0;
    logic [3:0]  led_model = 4'h0;
    logic [31:0] last_load = 32'h0;

    mem_stage_lsu dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid_i(ex_valid_i), .ex_mem_read_i(ex_mem_read_i), .ex_mem_write_i(ex_mem_write_i),
        .ex_funct3_i(ex_funct3_i), .ex_addr_i(ex_addr_i), .ex_wdata_i(ex_wdata_i),
        .lsu_stall_o(lsu_stall_o), .load_valid_o(load_valid_o), .load_data_o(load_data_o),
        .misaligned_o(misaligned_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .led_o(led_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: pick the addressed lane arithmetically, then sign/zero extend.
    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] word);
        logic [31:0] v;
        int unsigned off;
        off = addr % 4;
        if (f3 == 3'd0 || f3 == 3'd4) begin
            v = (word >> (8 * off)) & 32'hFF;
            if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
        end else if (f3 == 3'd1 || f3 == 3'd5) begin
            v = (word >> ((off >= 2) ? 16 : 0)) & 32'hFFFF;
            if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
        end else begin
            v = word;
        end
        return v;
    endfunction

    // Drives one op from a negedge, plays the RAM with gnt after gd cycles and
    // rvalid rv cycles after gnt, and returns at a negedge with the DUT idle.
    task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int gd, input int rv, input logic [31:0] rdata);
        logic        mis, mmio, retire, done, granted;
        int          exp_stall, exp_req, stall_n, lv_n, req_n, rv_n, cyc;
        logic [31:0] exp_be, exp_wd, exp_ld;
        mis  = ((f3 == 3'd1 || f3 == 3'd5) && (addr % 2 != 0)) || (f3 == 3'd2 && (addr % 4 != 0));
        mmio = (addr == 32'hFFFF_FFF0);
        if (mis || (mmio && wr)) exp_stall = 0;
        else if (mmio)           exp_stall = 1;
        else if (wr)             exp_stall = gd + 2;
        else                     exp_stall = gd + rv + 3;
        exp_req = (mis || mmio) ? 0 : gd + 1;
        exp_ld  = mmio ? {28'h0, led_model} : model_load(f3, addr, rdata);
        if (f3 == 3'd0 || f3 == 3'd4) begin
            exp_be = 32'd1 << (addr % 4);
            exp_wd = (wdata & 32'hFF) * 32'h0101_0101;
        end else if (f3 == 3'd1 || f3 == 3'd5) begin
            exp_be = (addr % 4 >= 2) ? 32'hC : 32'h3;
            exp_wd = (wdata & 32'hFFFF) * 32'h0001_0001;
        end else begin
            exp_be = 32'hF;
            exp_wd = wdata;
        end
        ex_valid_i = 1'b1; ex_mem_read_i = rd; ex_mem_write_i = wr;
        ex_funct3_i = f3; ex_addr_i = addr; ex_wdata_i = wdata;
        stall_n = 0; lv_n = 0; req_n = 0; rv_n = 0; cyc = 0; done = 1'b0; granted = 1'b0;
        while (!done && cyc < 80) begin
            cyc++;
            #1;
            if (lsu_stall_o) stall_n++;
            retire = !lsu_stall_o;
            mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = $urandom;
            if (mem_req_o) begin
                check("req_we", mem_we_o, wr);
                check("req_addr", mem_addr_o, addr & 32'hFFFF_FFFC);
                check("req_be", mem_be_o, exp_be);
                if (wr) check("req_wdata", mem_wdata_o, exp_wd);
                if (req_n == gd) begin
                    mem_gnt_i = 1'b1;
                    granted = 1'b1;
                end else begin
                    mem_rvalid_i = 1'($urandom_range(0, 1));
                end
                req_n++;
            end else if (granted && !wr) begin
                if (rv_n == rv) begin
                    mem_rvalid_i = 1'b1;
                    mem_rdata_i = rdata;
                end else begin
                    mem_gnt_i = 1'($urandom_range(0, 1));
                end
                rv_n++;
            end else begin
                mem_gnt_i = 1'($urandom_range(0, 1));
            end
            if (load_valid_o) begin
                lv_n++;
                check("load_data", load_data_o, exp_ld);
            end
            @(negedge clk);
            if (retire) begin
                ex_valid_i = 1'b0; ex_mem_read_i = 1'b0; ex_mem_write_i = 1'b0;
                ex_addr_i = $urandom;
                done = 1'b1;
            end
        end
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        check("retired", done, 1'b1);
        if (mmio && wr && !mis) led_model = wdata[3:0];
        if (!wr && !mis) last_load = exp_ld;
        #1;
        check("misaligned_pulse", misaligned_o, mis);
        check("led", led_o, led_model);
        check("stall_cycles", stall_n, exp_stall);
        check("req_cycles", req_n, exp_req);
        check("load_valid_count", lv_n, (!wr && !mis) ? 1 : 0);
        check("load_data_hold", load_data_o, last_load);
        check("idle_stall", lsu_stall_o, 1'b0);
        @(negedge clk);
        #1;
        check("misaligned_one_cycle", misaligned_o, 1'b0);
        check("idle_req", mem_req_o, 1'b0);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] r, a;
        logic        rd, wr;
        logic [2:0]  f3;
        #12;
        check("rst_stall", lsu_stall_o, 1'b0);
        check("rst_req", mem_req_o, 1'b0);
        check("rst_load_valid", load_valid_o, 1'b0);
        check("rst_load_data", load_data_o, 32'h0);
        check("rst_misaligned", misaligned_o, 1'b0);
        check("rst_led", led_o, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(1'b0, 1'b1, 3'd0, 32'h0000_1003, 32'h0000_00A5, 0, 0, 32'h0);
        run_op(1'b1, 1'b0, 3'd0, 32'h0000_2001, 32'h0, 0, 0, 32'h0000_8000);
        run_op(1'b1, 1'b0, 3'd4, 32'h0000_2001, 32'h0, 0, 0, 32'h0000_8000);
        run_op(1'b1, 1'b0, 3'd1, 32'h0000_2002, 32'h0, 0, 0, 32'h8001_0000);
        run_op(1'b1, 1'b0, 3'd2, 32'h0000_3000, 32'h0, 2, 1, 32'hDEAD_BEEF);
        run_op(1'b0, 1'b1, 3'd2, 32'hFFFF_FFF0, 32'h0000_000B, 0, 0, 32'h0);
        run_op(1'b1, 1'b0, 3'd2, 32'hFFFF_FFF0, 32'h0, 0, 0, 32'h0);
        run_op(1'b1, 1'b0, 3'd2, 32'h0000_1002, 32'h0, 0, 0, 32'h0);
        run_op(1'b1, 1'b0, 3'd1, 32'h0000_1001, 32'h0, 0, 0, 32'h0);
        run_op(1'b1, 1'b1, 3'd1, 32'h0000_4006, 32'h1234_5678, 1, 0, 32'h0);

        for (int i = 0; i < 60; i++) begin
            r  = $urandom;
            wr = r[0];
            rd = r[1] | ~wr;
            if (wr) f3 = 3'($urandom_range(0, 2));
            else begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4; default: f3 = 3'd5;
                endcase
            end
            a = $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFF0;
            run_op(rd, wr, f3, a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
        end

        // Reset while waiting for read data.
        ex_valid_i = 1'b1; ex_mem_read_i = 1'b1; ex_mem_write_i = 1'b0;
        ex_funct3_i = 3'd2; ex_addr_i = 32'h0000_4000;
        #1 check("rstw_idle_stall", lsu_stall_o, 1'b1);
        @(negedge clk);
        #1 check("rstw_req", mem_req_o, 1'b1);
        mem_gnt_i = 1'b1;
        @(negedge clk);
        mem_gnt_i = 1'b0;
        #1 check("rstw_wait_stall", lsu_stall_o, 1'b1);
        rst_n = 1'b0; ex_valid_i = 1'b0; ex_mem_read_i = 1'b0;
        #1;
        check("rstw_req_drop", mem_req_o, 1'b0);
        check("rstw_stall_drop", lsu_stall_o, 1'b0);
        check("rstw_load_valid", load_valid_o, 1'b0);
        check("rstw_led", led_o, 4'h0);
        check("rstw_load_data", load_data_o, 32'h0);
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hCAFE_F00D;
        @(negedge clk);
        rst_n = 1'b1;
        led_model = 4'h0; last_load = 32'h0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("post_rst_load_valid", load_valid_o, 1'b0);
            check("post_rst_stall", lsu_stall_o, 1'b0);
            check("post_rst_load_data", load_data_o, 32'h0);
            @(negedge clk);
        end
        mem_rvalid_i = 1'b0;
        run_op(1'b1, 1'b0, 3'd5, 32'h0000_5002, 32'h0, 1, 2, 32'hF00D_1234);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
